// File: rtl/alu_req_arbiter_if.sv
// Requester, shared-ALU and response signals for the two-port ALU arbiter.
// slave = arbiter side, master = requesters/ALU/response-sink side.
interface alu_req_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [5:0]  req0_op;
  logic [63:0] req0_a;
  logic [63:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [5:0]  req1_op;
  logic [63:0] req1_a;
  logic [63:0] req1_b;
  logic [5:0]  alu_op;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic        alu_en;
  logic [31:0] alu_c;
  logic [6:0]  alu_flags;
  logic        alu_done;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_c;
  logic [6:0]  rsp_flags;
  logic        rsp_err;
  logic        rsp_tmo;
  logic        busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_c, alu_flags, alu_done, rsp_ready,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b, alu_en,
    output rsp_valid, rsp_id, rsp_c, rsp_flags, rsp_err, rsp_tmo, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_c, alu_flags, alu_done, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b, alu_en,
    input  rsp_valid, rsp_id, rsp_c, rsp_flags, rsp_err, rsp_tmo, busy
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one op in flight.
// Single-cycle ops respond 2 cycles after accept; response held until rsp_ready.
module alu_req_arbiter #(
  parameter logic [5:0] MC_OP   = 6'd6,
  parameter int         TIMEOUT = 64
) (
  input logic            clk,
  input logic            rst_n,
  alu_req_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  logic          r_prio;
  logic [CW-1:0] r_cnt;
  logic [5:0]    r_op;
  logic [63:0]   r_a;
  logic [63:0]   r_b;
  logic          r_id;
  logic [31:0]   r_c;
  logic [6:0]    r_flags;
  logic          r_err;
  logic          r_tmo;

  logic          w_idle;
  logic          w_gnt0;
  logic          w_gnt1;
  logic [5:0]    w_sel_op;
  logic          w_legal;

  assign w_idle   = (r_state == S_IDLE);
  // Grants are masked while reset is asserted so nothing is accepted on a reset edge.
  assign w_gnt0   = rst_n && w_idle && bus.req0_valid && (!bus.req1_valid || !r_prio);
  assign w_gnt1   = rst_n && w_idle && bus.req1_valid && (!bus.req0_valid || r_prio);
  assign w_sel_op = w_gnt1 ? bus.req1_op : bus.req0_op;
  assign w_legal  = (w_sel_op < 6'd31) || (w_sel_op == 6'd32);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_prio  <= 1'b0;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_id    <= 1'b0;
      r_c     <= '0;
      r_flags <= '0;
      r_err   <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_op   <= w_sel_op;
            r_a    <= w_gnt1 ? bus.req1_a : bus.req0_a;
            r_b    <= w_gnt1 ? bus.req1_b : bus.req0_b;
            r_id   <= w_gnt1;
            r_prio <= w_gnt0;
            r_tmo  <= 1'b0;
            if (w_legal) begin
              r_err   <= 1'b0;
              r_state <= S_ISSUE;
            end else begin
              r_err   <= 1'b1;
              r_c     <= '0;
              r_flags <= '0;
              r_state <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          if (r_op == MC_OP) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end else begin
            r_c     <= bus.alu_c;
            r_flags <= bus.alu_flags;
            r_state <= S_RESP;
          end
        end
        S_WAIT: begin
          // A completion on the final counted cycle still wins over the timeout.
          if (bus.alu_done) begin
            r_c     <= bus.alu_c;
            r_flags <= bus.alu_flags;
            r_state <= S_RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_c     <= '0;
            r_flags <= '0;
            r_tmo   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.alu_op     = r_op;
  assign bus.alu_a      = r_a;
  assign bus.alu_b      = r_b;
  assign bus.alu_en     = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign bus.rsp_valid  = (r_state == S_RESP);
  assign bus.rsp_id     = r_id;
  assign bus.rsp_c      = r_c;
  assign bus.rsp_flags  = r_flags;
  assign bus.rsp_err    = r_err;
  assign bus.rsp_tmo    = r_tmo;
  assign bus.busy       = !w_idle;
endmodule

// File: doc/alu_req_arbiter.md
ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 Parameter: MC_OP, 6'd6, opcode treated as multi-cycle (division); all other legal opcodes are single-cycle.
REQ-002 Parameter: TIMEOUT, 64, maximum cycles in WAIT before forced completion.
REQ-003 Port: clk  in  1  sole clock; all state changes on rising edge.
REQ-004 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-005 Ports: req0_valid / req1_valid  in  1  requester N has an operation pending.
REQ-006 Ports: req0_ready / req1_ready  out  1  requester N accepted this cycle when valid&&ready.
REQ-007 Ports: req0_op / req1_op  in  6; req0_a / req1_a  in  64; req0_b / req1_b  in  64  operation and operands.
REQ-008 Ports: alu_op  out  6; alu_a  out  64; alu_b  out  64; alu_en  out  1  drive to the shared ALU.
REQ-009 Ports: alu_c  in  32; alu_flags  in  7; alu_done  in  1  ALU result, flags, multi-cycle completion.
REQ-010 Ports: rsp_valid  out  1; rsp_ready  in  1; rsp_id  out  1 (requester index); rsp_c  out  32; rsp_flags  out  7; rsp_err  out  1 (illegal opcode); rsp_tmo  out  1 (timeout).
REQ-011 Port: busy  out  1  high in every state except IDLE.

Function
REQ-012 FSM states: IDLE, ISSUE, WAIT, RESP; one operation in flight at a time.
REQ-013 IDLE: reqN_ready = valid_N && (!valid_other || prio==N); at most one ready high per cycle; both low outside IDLE.
REQ-014 prio resets to 0; on each accept prio becomes the index of the non-granted requester (round-robin).
REQ-015 On accept: latch op, a, b, id into internal registers; go to ISSUE (legal op) or RESP with rsp_err=1 (illegal op).
REQ-016 Illegal opcodes: 31 and 33..63; no ALU issue, rsp_c=0, rsp_flags=0, rsp_err=1.
REQ-017 alu_op/alu_a/alu_b always driven from latched registers; alu_en=1 only in ISSUE and WAIT.
REQ-018 ISSUE, op != MC_OP: capture alu_c/alu_flags at the end of the ISSUE cycle; go to RESP.
REQ-019 ISSUE, op == MC_OP: go to WAIT, clear timeout counter; operands and alu_en held stable.
REQ-020 WAIT: alu_done=1 captures alu_c/alu_flags, goes to RESP; alu_done ignored in all other states.
REQ-021 WAIT: counter increments each cycle; on reaching TIMEOUT without alu_done go to RESP with rsp_c=0, rsp_flags=0, rsp_tmo=1.
REQ-022 Single-cycle latency: accept in cycle T, rsp_valid high from cycle T+2.
REQ-023 RESP: rsp_valid=1; rsp_id/rsp_c/rsp_flags/rsp_err/rsp_tmo held stable until rsp_valid&&rsp_ready; then IDLE next cycle.
REQ-024 rsp_err and rsp_tmo are never both 1; both cleared on entry to ISSUE or RESP of the next operation.
REQ-025 Requests arriving outside IDLE wait (no ready); requesters SHALL hold valid and payload until accepted.

Reset
REQ-026 rst_n low at a clock edge: state=IDLE, prio=0, counter=0, all outputs 0 (ready, alu_en, alu_op/a/b, rsp_*, busy), from any state including mid-WAIT.
REQ-027 An in-flight operation aborted by reset produces no response; a late alu_done after reset is ignored.

Verification
REQ-028 req0 op=1 a=5 b=7, ALU returns c=12 flags=0 -> rsp_valid at T+2, rsp_id=0, rsp_c=12, one alu_en pulse.
REQ-029 Both valid from reset, op=11 each -> req0 served first, then req1; alternating grants over 4 back-to-back requests.
REQ-030 req1 op=6, alu_done asserted 10 cycles after WAIT entry with c=3 -> rsp_c=3, rsp_id=1, alu_en high throughout ISSUE+WAIT.
REQ-031 op=6, alu_done never asserted -> rsp_tmo=1, rsp_c=0 after TIMEOUT=64 WAIT cycles; busy then drops after rsp_ready.
REQ-032 op=40 -> rsp_err=1, rsp_c=0, alu_en never high; rsp_ready held low 5 cycles -> outputs stable throughout.
REQ-033 rst_n low during WAIT -> next edge all outputs 0, state IDLE; subsequent alu_done produces no rsp_valid.
